// File: rtl/bloom_window_ctrl.sv
// Sequencer for the time-windowed bloom SRAM line update path.
// Round-robin insert/query arbitration, one read-modify-write per request,
// and the window clock (tick -> bucket -> loop) that stamps every line.
module bloom_window_ctrl #(
  parameter int unsigned DATA_WIDTH       = 72,
  parameter int unsigned ADDR_WIDTH       = 19,
  parameter int unsigned NUM_BUCKETS      = 14,
  parameter int unsigned BUCKET_SZ        = 4,
  parameter int unsigned BITS_SHIFT       = 4,
  parameter int unsigned BLOOM_INIT_POS   = 16,
  parameter int unsigned TICK_WIDTH       = 24,
  parameter int unsigned TICKS_PER_BUCKET = 1000000
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ins_req,
  input  logic [ADDR_WIDTH-1:0]                  ins_addr,
  input  logic [BUCKET_SZ-1:0]                   ins_mask,
  output logic                                   ins_done,
  input  logic                                   qry_req,
  input  logic [ADDR_WIDTH-1:0]                  qry_addr,
  input  logic [BUCKET_SZ-1:0]                   qry_mask,
  output logic                                   qry_done,
  output logic                                   qry_hit,
  output logic [ADDR_WIDTH-1:0]                  sram_addr,
  output logic                                   sram_rd_req,
  input  logic                                   sram_rd_ack,
  input  logic                                   sram_rd_vld,
  input  logic [DATA_WIDTH-1:0]                  sram_rd_data,
  output logic                                   sram_wr_req,
  output logic [DATA_WIDTH-1:0]                  sram_wr_data,
  input  logic                                   sram_wr_ack,
  output logic [DATA_WIDTH-1:0]                  upd_data,
  output logic [BITS_SHIFT-1:0]                  upd_cur_bucket,
  output logic [BLOOM_INIT_POS-BITS_SHIFT-1:0]   upd_cur_loop,
  input  logic [DATA_WIDTH-1:0]                  upd_result,
  output logic [BITS_SHIFT-1:0]                  cur_bucket,
  output logic [BLOOM_INIT_POS-BITS_SHIFT-1:0]   cur_loop
);

  localparam int unsigned LOOP_W = BLOOM_INIT_POS - BITS_SHIFT;
  localparam logic [TICK_WIDTH-1:0] TICK_LAST   = TICK_WIDTH'(TICKS_PER_BUCKET - 1);
  localparam logic [BITS_SHIFT-1:0] BUCKET_LAST = BITS_SHIFT'(NUM_BUCKETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_UPDATE,
    S_WR,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [TICK_WIDTH-1:0]   tick_q, tick_d;
  logic [BITS_SHIFT-1:0]   bucket_q, bucket_d;
  logic [LOOP_W-1:0]       loop_q, loop_d;
  logic                    rr_qry_q, rr_qry_d;
  logic                    is_qry_q, is_qry_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [BUCKET_SZ-1:0]    mask_q, mask_d;
  logic [BITS_SHIFT-1:0]   snap_bucket_q, snap_bucket_d;
  logic [LOOP_W-1:0]       snap_loop_q, snap_loop_d;
  logic [DATA_WIDTH-1:0]   upd_data_q, upd_data_d;
  logic [DATA_WIDTH-1:0]   wr_buf_q, wr_buf_d;
  logic                    hit_q, hit_d;

  logic                    grant_qry;
  logic                    hit_any;
  logic                    hit_calc;
  logic [DATA_WIDTH-1:0]   mask_line;

  // Window clock: tick wraps every TICKS_PER_BUCKET cycles, carrying into bucket then loop.
  always_comb begin
    tick_d   = tick_q + 1'b1;
    bucket_d = bucket_q;
    loop_d   = loop_q;
    if (tick_q == TICK_LAST) begin
      tick_d = '0;
      if (bucket_q == BUCKET_LAST) begin
        bucket_d = '0;
        loop_d   = loop_q + 1'b1;
      end else begin
        bucket_d = bucket_q + 1'b1;
      end
    end
  end

  // Query hit over the aged bloom field and the insert mask aligned to the newest bucket.
  always_comb begin
    hit_any = 1'b0;
    for (int unsigned b = 0; b < NUM_BUCKETS; b++) begin
      if ((upd_result[BLOOM_INIT_POS + b*BUCKET_SZ +: BUCKET_SZ] & mask_q) == mask_q) begin
        hit_any = 1'b1;
      end
    end
    hit_calc  = (mask_q != '0) && hit_any;
    mask_line = {mask_q, {(DATA_WIDTH-BUCKET_SZ){1'b0}}};
  end

  // Transaction FSM: next state, grant and datapath captures.
  always_comb begin
    state_d       = state_q;
    rr_qry_d      = rr_qry_q;
    is_qry_d      = is_qry_q;
    addr_d        = addr_q;
    mask_d        = mask_q;
    snap_bucket_d = snap_bucket_q;
    snap_loop_d   = snap_loop_q;
    upd_data_d    = upd_data_q;
    wr_buf_d      = wr_buf_q;
    hit_d         = hit_q;
    // Pointer only decides contested grants and only moves on them, so a
    // lone requester never steals the other side's next turn.
    grant_qry     = (ins_req && qry_req) ? rr_qry_q : qry_req;
    unique case (state_q)
      S_IDLE: begin
        if (ins_req || qry_req) begin
          state_d       = S_RD_REQ;
          is_qry_d      = grant_qry;
          addr_d        = grant_qry ? qry_addr : ins_addr;
          mask_d        = grant_qry ? qry_mask : ins_mask;
          snap_bucket_d = bucket_q;
          snap_loop_d   = loop_q;
          if (ins_req && qry_req) begin
            rr_qry_d = ~rr_qry_q;
          end
        end
      end
      S_RD_REQ: begin
        if (sram_rd_ack) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (sram_rd_vld) begin
          upd_data_d = sram_rd_data;
          state_d    = S_UPDATE;
        end
      end
      S_UPDATE: begin
        wr_buf_d = is_qry_q ? upd_result : (upd_result | mask_line);
        hit_d    = is_qry_q && hit_calc;
        state_d  = S_WR;
      end
      S_WR: begin
        if (sram_wr_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset overrides every other update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tick_q        <= '0;
      bucket_q      <= '0;
      loop_q        <= '0;
      rr_qry_q      <= 1'b0;
      is_qry_q      <= 1'b0;
      addr_q        <= '0;
      mask_q        <= '0;
      snap_bucket_q <= '0;
      snap_loop_q   <= '0;
      upd_data_q    <= '0;
      wr_buf_q      <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      bucket_q      <= bucket_d;
      loop_q        <= loop_d;
      rr_qry_q      <= rr_qry_d;
      is_qry_q      <= is_qry_d;
      addr_q        <= addr_d;
      mask_q        <= mask_d;
      snap_bucket_q <= snap_bucket_d;
      snap_loop_q   <= snap_loop_d;
      upd_data_q    <= upd_data_d;
      wr_buf_q      <= wr_buf_d;
      hit_q         <= hit_d;
    end
  end

  // Strobes and completions decoded from the registered state.
  always_comb begin
    sram_rd_req    = (state_q == S_RD_REQ);
    sram_wr_req    = (state_q == S_WR);
    ins_done       = (state_q == S_DONE) && !is_qry_q;
    qry_done       = (state_q == S_DONE) && is_qry_q;
    qry_hit        = (state_q == S_DONE) && is_qry_q && hit_q;
    sram_addr      = addr_q;
    sram_wr_data   = wr_buf_q;
    upd_data       = upd_data_q;
    upd_cur_bucket = snap_bucket_q;
    upd_cur_loop   = snap_loop_q;
    cur_bucket     = bucket_q;
    cur_loop       = loop_q;
  end

endmodule

// File: tb/tb_bloom_window_ctrl.sv
// Directed bench for bloom_window_ctrl with a fast window clock (4 ticks/bucket),
// a zero/one-wait SRAM responder and a behavioural line-aging datapath.
module tb_bloom_window_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ins_req, qry_req;
  logic [18:0] ins_addr, qry_addr;
  logic [3:0]  ins_mask, qry_mask;
  logic        ins_done, qry_done, qry_hit;
  logic [18:0] sram_addr;
  logic        sram_rd_req, sram_rd_ack, sram_rd_vld;
  logic [71:0] sram_rd_data;
  logic        sram_wr_req, sram_wr_ack;
  logic [71:0] sram_wr_data;
  logic [71:0] upd_data, upd_result;
  logic [3:0]  upd_cur_bucket, cur_bucket;
  logic [11:0] upd_cur_loop, cur_loop;

  always #5 clk = ~clk;

  bloom_window_ctrl #(
    .DATA_WIDTH(72), .ADDR_WIDTH(19), .NUM_BUCKETS(14), .BUCKET_SZ(4),
    .BITS_SHIFT(4), .BLOOM_INIT_POS(16), .TICK_WIDTH(24), .TICKS_PER_BUCKET(4)
  ) dut (
    .clk(clk), .reset(reset),
    .ins_req(ins_req), .ins_addr(ins_addr), .ins_mask(ins_mask), .ins_done(ins_done),
    .qry_req(qry_req), .qry_addr(qry_addr), .qry_mask(qry_mask), .qry_done(qry_done),
    .qry_hit(qry_hit), .sram_addr(sram_addr), .sram_rd_req(sram_rd_req),
    .sram_rd_ack(sram_rd_ack), .sram_rd_vld(sram_rd_vld), .sram_rd_data(sram_rd_data),
    .sram_wr_req(sram_wr_req), .sram_wr_data(sram_wr_data), .sram_wr_ack(sram_wr_ack),
    .upd_data(upd_data), .upd_cur_bucket(upd_cur_bucket), .upd_cur_loop(upd_cur_loop),
    .upd_result(upd_result), .cur_bucket(cur_bucket), .cur_loop(cur_loop)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Aging datapath: shift bloom toward older buckets by elapsed buckets, restamp.
  function automatic logic [71:0] age_line(input logic [71:0] line, input logic [3:0] cb,
                                           input logic [11:0] cl);
    int now_i, then_i, age;
    logic [55:0] bloom;
    now_i  = int'(cl) * 14 + int'(cb);
    then_i = int'(line[11:0]) * 14 + int'(line[15:12]);
    age    = now_i - then_i;
    if (age < 0) age = 0;
    bloom = line[71:16];
    if (age >= 14) bloom = '0;
    else           bloom = bloom >> (4 * age);
    return {bloom, cb, cl};
  endfunction

  assign upd_result = age_line(upd_data, upd_cur_bucket, upd_cur_loop);

  // SRAM responder (auto) with a manual override path.
  bit          auto_sram  = 1'b1;
  int          rd_ack_lat = 0;
  logic [71:0] rd_line    = '0;
  logic        a_ack = 1'b0, a_vld = 1'b0, a_wack = 1'b0;
  logic [71:0] a_data = '0;
  logic        m_ack = 1'b0, m_vld = 1'b0;
  logic [71:0] m_data = '0;

  assign sram_rd_ack  = auto_sram ? a_ack  : m_ack;
  assign sram_rd_vld  = auto_sram ? a_vld  : m_vld;
  assign sram_rd_data = auto_sram ? a_data : m_data;
  assign sram_wr_ack  = auto_sram ? a_wack : 1'b0;

  initial begin
    int  cnt;
    bit  pend;
    cnt  = 0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      a_vld  = pend;
      a_data = pend ? rd_line : '0;
      pend   = 1'b0;
      if (sram_rd_req) begin
        if (cnt >= rd_ack_lat) begin
          a_ack = 1'b1; pend = 1'b1; cnt = 0;
        end else begin
          a_ack = 1'b0; cnt++;
        end
      end else begin
        a_ack = 1'b0; cnt = 0;
      end
      a_wack = sram_wr_req;
    end
  end

  task automatic do_reset();
    reset = 1'b1; ins_req = 1'b0; qry_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_bucket(input logic [3:0] b);
    int n;
    n = 0;
    while (cur_bucket != b && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_bucket", {8'd0, cur_bucket}, {8'd0, b});
  endtask

  task automatic run_txn(input bit qry, input logic [18:0] addr, input logic [3:0] mask,
                         input logic [71:0] line, output int lat, output logic [71:0] wdata,
                         output logic [18:0] waddr, output logic hit, output logic done_qry,
                         output logic [3:0] snap_b, output logic [3:0] live_b,
                         output logic again);
    rd_line = line;
    lat = 0; wdata = '0; waddr = '0; hit = 1'b0; done_qry = 1'b0;
    snap_b = '0; live_b = '0;
    if (qry) begin qry_req = 1'b1; qry_addr = addr; qry_mask = mask; end
    else     begin ins_req = 1'b1; ins_addr = addr; ins_mask = mask; end
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (sram_wr_req) begin
        wdata = sram_wr_data; waddr = sram_addr;
        snap_b = upd_cur_bucket; live_b = cur_bucket;
      end
      if (ins_done || qry_done) begin
        hit = qry_hit; done_qry = qry_done;
        break;
      end
    end
    ins_req = 1'b0; qry_req = 1'b0;
    @(negedge clk);
    again = ins_done | qry_done;
  endtask

  task automatic arb_round(output logic first_qry, output int ndone);
    ins_req = 1'b1; qry_req = 1'b1; ndone = 0; first_qry = 1'b0;
    for (int i = 0; i < 60 && ndone < 2; i++) begin
      @(negedge clk);
      if (ins_done) begin
        if (ndone == 0) first_qry = 1'b0;
        ndone++; ins_req = 1'b0;
      end
      if (qry_done) begin
        if (ndone == 0) first_qry = 1'b1;
        ndone++; qry_req = 1'b0;
      end
    end
    ins_req = 1'b0; qry_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, nd;
    logic [71:0] wd;
    logic [18:0] wa;
    logic        hit, dq, again, fq;
    logic [3:0]  sb, lb;
    logic [4:0]  strobes;

    ins_addr = '0; qry_addr = '0; ins_mask = '0; qry_mask = '0;
    do_reset();

    // Reset state
    chk("rst_strobes", {67'd0, sram_rd_req, sram_wr_req, ins_done, qry_done, qry_hit}, 72'd0);
    chk("rst_window",  {56'd0, cur_loop, cur_bucket}, 72'd0);
    chk("rst_addr",    {53'd0, sram_addr}, 72'd0);
    chk("rst_upd",     upd_data, 72'd0);
    chk("rst_wrdata",  sram_wr_data, 72'd0);

    // Window clock: bucket steps every 4 cycles, wraps after 14 with loop+1
    strobes = '0;
    for (int n = 1; n <= 56; n++) begin
      @(negedge clk);
      strobes |= {sram_rd_req, sram_wr_req, ins_done, qry_done, qry_hit};
      if (n % 4 == 0)
        chk($sformatf("window@%0d", n), {56'd0, cur_loop, cur_bucket},
            {56'd0, 12'(n / 56), 4'((n / 4) % 14)});
    end
    chk("idle_strobes", {67'd0, strobes}, 72'd0);

    // Insert at bucket 3, loop 0 into an empty line
    do_reset();
    wait_bucket(4'd3);
    run_txn(1'b0, 19'h00010, 4'b0101, 72'h0, lat, wd, wa, hit, dq, sb, lb, again);
    chk("ins_lat",    lat, 5);
    chk("ins_addr",   {53'd0, wa}, {53'd0, 19'h00010});
    chk("ins_wdata",  wd, 72'h500000000000003000);
    chk("ins_type",   {71'd0, dq}, 72'd0);
    chk("ins_snap",   {68'd0, sb}, 72'd3);
    chk("ins_live",   {68'd0, lb}, 72'd4);
    chk("ins_pulse1", {71'd0, again}, 72'd0);

    // Queries at the same stamp
    do_reset();
    wait_bucket(4'd3);
    run_txn(1'b1, 19'h00010, 4'b0101, 72'h500000000000003000, lat, wd, wa, hit, dq, sb, lb, again);
    chk("q5_hit",   {71'd0, hit}, 72'd1);
    chk("q5_type",  {71'd0, dq}, 72'd1);
    chk("q5_wdata", wd, 72'h500000000000003000);
    chk("q5_lat",   lat, 5);
    do_reset();
    wait_bucket(4'd3);
    run_txn(1'b1, 19'h00010, 4'b1000, 72'h500000000000003000, lat, wd, wa, hit, dq, sb, lb, again);
    chk("q8_hit",   {71'd0, hit}, 72'd0);
    do_reset();
    wait_bucket(4'd3);
    run_txn(1'b1, 19'h00010, 4'b0000, 72'h500000000000003000, lat, wd, wa, hit, dq, sb, lb, again);
    chk("q0_hit",   {71'd0, hit}, 72'd0);

    // Aging: same line queried with snapshot at bucket 5
    do_reset();
    wait_bucket(4'd5);
    run_txn(1'b1, 19'h00010, 4'b0101, 72'h500000000000003000, lat, wd, wa, hit, dq, sb, lb, again);
    chk("age_wdata", wd, 72'h005000000000005000);
    chk("age_hit",   {71'd0, hit}, 72'd1);

    // One SRAM read wait cycle adds one cycle of latency
    do_reset();
    rd_ack_lat = 1;
    run_txn(1'b0, 19'h7FFFF, 4'b1111, 72'h0, lat, wd, wa, hit, dq, sb, lb, again);
    rd_ack_lat = 0;
    chk("wait_lat",   lat, 6);
    chk("wait_addr",  {53'd0, wa}, {53'd0, 19'h7FFFF});
    chk("wait_wdata", wd, 72'hF00000000000000000);

    // Arbitration: contested grant alternates
    do_reset();
    ins_addr = 19'h00001; qry_addr = 19'h00002; ins_mask = 4'b0101; qry_mask = 4'b0101;
    rd_line = '0;
    arb_round(fq, nd);
    chk("arb1_first", {71'd0, fq}, 72'd0);
    chk("arb1_count", nd, 2);
    arb_round(fq, nd);
    chk("arb2_first", {71'd0, fq}, 72'd1);
    chk("arb2_count", nd, 2);

    // Reset in RD_WAIT, then a stray rd_vld while idle
    do_reset();
    auto_sram = 1'b0;
    m_ack = 1'b0; m_vld = 1'b0; m_data = '0;
    qry_addr = 19'h00033; qry_mask = 4'b0001; qry_req = 1'b1;
    @(negedge clk);
    chk("mid_rdreq", {71'd0, sram_rd_req}, 72'd1);
    m_ack = 1'b1;
    @(negedge clk);
    m_ack = 1'b0;
    chk("mid_rdwait", {71'd0, sram_rd_req}, 72'd0);
    reset = 1'b1; qry_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_addr", {53'd0, sram_addr}, 72'd0);
    m_vld = 1'b1; m_data = 72'hABCDEF0123456789AB;
    @(negedge clk);
    m_vld = 1'b0; m_data = '0;
    strobes = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      strobes |= {sram_rd_req, sram_wr_req, ins_done, qry_done, qry_hit};
    end
    chk("mid_quiet", {67'd0, strobes}, 72'd0);
    chk("mid_upd",   upd_data, 72'd0);
    auto_sram = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bloom_window_ctrl.md
Name: bloom_window_ctrl

Overview:
Sequencer for the time-windowed bloom SRAM line update path. Arbitrates insert (data packet) and query (ack) requests round-robin and runs one SRAM read-modify-write per request. Each transaction drives the external line-update datapath with a snapshot of the window clock (cur_bucket/cur_loop) and writes the aged line back. Owns the window clock, which advances one bucket every TICKS_PER_BUCKET cycles.

Parameters:
DATA_WIDTH, 72, SRAM line width
ADDR_WIDTH, 19, SRAM word address width
NUM_BUCKETS, 14, buckets per bloom line
BUCKET_SZ, 4, bits per bucket
BITS_SHIFT, 4, width of bucket stamp field
BLOOM_INIT_POS, 16, LSB of bloom field; [BLOOM_INIT_POS-1:0] holds the {bucket, loop} stamp
TICK_WIDTH, 24, width of tick counter
TICKS_PER_BUCKET, 1000000, cycles per bucket advance (must be >= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ins_req  in  1  insert request, held until ins_done
ins_addr  in  ADDR_WIDTH  insert line address
ins_mask  in  BUCKET_SZ  bits to set in newest bucket
ins_done  out  1  one-cycle completion pulse
qry_req  in  1  query request, held until qry_done
qry_addr  in  ADDR_WIDTH  query line address
qry_mask  in  BUCKET_SZ  bits to test
qry_done  out  1  one-cycle completion pulse
qry_hit  out  1  query result, valid only while qry_done=1
sram_addr  out  ADDR_WIDTH  SRAM address, stable from RD_REQ through WR
sram_rd_req  out  1  read strobe, held until sram_rd_ack
sram_rd_ack  in  1  read accepted
sram_rd_vld  in  1  read data valid
sram_rd_data  in  DATA_WIDTH  read data
sram_wr_req  out  1  write strobe, held until sram_wr_ack
sram_wr_data  out  DATA_WIDTH  write data
sram_wr_ack  in  1  write accepted
upd_data  out  DATA_WIDTH  line sent to update datapath
upd_cur_bucket  out  BITS_SHIFT  bucket snapshot for datapath
upd_cur_loop  out  BLOOM_INIT_POS-BITS_SHIFT  loop snapshot for datapath
upd_result  in  DATA_WIDTH  aged line returned combinationally by datapath
cur_bucket  out  BITS_SHIFT  live window bucket
cur_loop  out  BLOOM_INIT_POS-BITS_SHIFT  live window loop

Behaviour:
- Reset (synchronous, active-high): all outputs 0, tick=0, cur_bucket=0, cur_loop=0, state IDLE, RR pointer = insert. Reset wins over every other event.
- Window clock: tick increments every cycle. At tick==TICKS_PER_BUCKET-1, tick goes to 0 and cur_bucket increments. If cur_bucket==NUM_BUCKETS-1, it wraps to 0 and cur_loop increments (modulo 2^12). The clock runs regardless of FSM state.
- FSM: IDLE -> RD_REQ -> RD_WAIT -> UPDATE -> WR -> DONE -> IDLE.
- IDLE: when either request is high, grant and latch addr, mask, type, and snapshot {cur_bucket, cur_loop}. Go to RD_REQ.
- Arbitration: a single requester is granted directly. If both are high, the RR pointer side wins, and the pointer flips to the other side after each grant.
- RD_REQ: sram_rd_req=1 until sram_rd_ack is sampled high, then go to RD_WAIT.
- RD_WAIT: capture sram_rd_data into upd_data on the sram_rd_vld cycle, then go to UPDATE. sram_rd_vld outside RD_WAIT is ignored.
- UPDATE (1 cycle): register upd_result into the write buffer. For an insert, OR ins_mask into the newest bucket [DATA_WIDTH-1:DATA_WIDTH-BUCKET_SZ]. For a query, compute hit = (mask!=0) AND (some bucket b of the aged bloom field satisfies (b & mask)==mask).
- upd_cur_bucket/upd_cur_loop carry the snapshot for the whole transaction and are never taken from the live clock mid-transaction.
- WR: sram_wr_req=1 with sram_wr_data until sram_wr_ack. Both request types write back, so aging persists.
- DONE: pulse ins_done or qry_done for one cycle, with qry_hit for a query. Return to IDLE.
- IDLE does not sample requests during DONE. A requester must drop req the cycle after done, or it is taken as a new request.
- Latency with zero-wait SRAM (rd_ack in RD_REQ, rd_vld the next cycle, wr_ack immediate): done is asserted 5 cycles after the accept cycle. Each SRAM wait cycle adds 1 cycle.
- Only one transaction is in flight, so there is no same-address hazard.

Test Plan:
- Window clock (TICKS_PER_BUCKET=4): reset, run 56 cycles -> cur_bucket steps 0..13 every 4 cycles, then wraps to 0 with cur_loop=1. All strobes and dones stay 0.
- Insert (TICKS_PER_BUCKET=4): at cur_bucket=3, cur_loop=0, insert addr 0x00010, mask 4'b0101; SRAM returns 72'h0 -> sram_addr=0x00010, sram_wr_data=72'h500000000000003000, ins_done pulses exactly 5 cycles after accept.
- Query at the same stamp: line 72'h500000000000003000 -> mask 4'b0101 gives qry_hit=1; mask 4'b1000 gives qry_hit=0; mask 4'b0000 gives qry_hit=0.
- Aging: query the same line with the snapshot at bucket 5, loop 0 -> sram_wr_data=72'h005000000000005000 and qry_hit=1 for mask 4'b0101.
- Arbitration: assert ins_req and qry_req together after reset -> insert done first, then query. Repeat with both held -> query served first, confirming alternation.
- Reset mid-op: assert reset during RD_WAIT -> IDLE next cycle, no sram_wr_req, no done pulse, and a later stray sram_rd_vld is ignored.
